// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: NEC IR frame serialiser with carrier-modulated LED drive.
// Define NEC_TX_REPEAT_EN to emit NEC repeat codes while tx_repeat is held high.
module nec_ir_transmitter #(
    parameter int UNIT_CYC     = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int FRAME_UNITS  = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tx_data,
    input  logic        tx_start,
    input  logic        tx_repeat,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ir_env,
    output logic        ir_out
);
    localparam int CW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef NEC_TX_REPEAT_EN
        , REP_SPACE
`endif
    } state_t;

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_idx;
    logic [CW-1:0] cnt_cyc;
    logic [7:0]  cnt_unit;
    logic [3:0]  seg_left;
    logic [HW-1:0] car_cnt;
    logic        carrier;
    logic        unit_end;
    logic        seg_end;
    logic        car_wrap;

`ifdef NEC_TX_REPEAT_EN
    logic rep_frame;
`else
    logic unused_repeat;
    assign unused_repeat = tx_repeat;
`endif

    assign unit_end = cnt_cyc == CW'(UNIT_CYC - 1);
    assign seg_end  = unit_end && seg_left == 4'd0;
    assign car_wrap = car_cnt == HW'(CARRIER_HALF - 1);
    assign ir_out   = ir_env & carrier;

    // seg_left holds the remaining units of the current mark/space, minus one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            cnt_cyc   <= '0;
            cnt_unit  <= '0;
            seg_left  <= '0;
            car_cnt   <= '0;
            carrier   <= 1'b0;
            ir_env    <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef NEC_TX_REPEAT_EN
            rep_frame <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                cnt_cyc <= unit_end ? '0 : cnt_cyc + 1'b1;
                if (unit_end) begin
                    cnt_unit <= cnt_unit + 1'b1;
                    seg_left <= seg_left - 1'b1;
                end
            end
            if (ir_env) begin
                car_cnt <= car_wrap ? '0 : car_cnt + 1'b1;
                if (car_wrap) carrier <= ~carrier;
            end
            case (state)
                IDLE: if (tx_start) begin
                    state     <= LEAD_MARK;
                    shift_reg <= tx_data;
                    bit_idx   <= '0;
                    cnt_cyc   <= '0;
                    cnt_unit  <= '0;
                    seg_left  <= 4'd15;
                    ir_env    <= 1'b1;
                    carrier   <= 1'b1;
                    car_cnt   <= '0;
                    tx_busy   <= 1'b1;
`ifdef NEC_TX_REPEAT_EN
                    rep_frame <= 1'b0;
`endif
                end
                LEAD_MARK: if (seg_end) begin
                    ir_env <= 1'b0;
`ifdef NEC_TX_REPEAT_EN
                    state    <= rep_frame ? REP_SPACE : LEAD_SPACE;
                    seg_left <= rep_frame ? 4'd3 : 4'd7;
`else
                    state    <= LEAD_SPACE;
                    seg_left <= 4'd7;
`endif
                end
                LEAD_SPACE: if (seg_end) begin
                    state    <= BIT_MARK;
                    seg_left <= 4'd0;
                    ir_env   <= 1'b1;
                    carrier  <= 1'b1;
                    car_cnt  <= '0;
                end
                BIT_MARK: if (seg_end) begin
                    state    <= BIT_SPACE;
                    seg_left <= shift_reg[0] ? 4'd2 : 4'd0;
                    ir_env   <= 1'b0;
                end
                BIT_SPACE: if (seg_end) begin
                    state     <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 1'b1;
                    seg_left  <= 4'd0;
                    ir_env    <= 1'b1;
                    carrier   <= 1'b1;
                    car_cnt   <= '0;
                end
                STOP_MARK: if (seg_end) begin
                    state  <= GAP;
                    ir_env <= 1'b0;
                end
                GAP: if (unit_end && cnt_unit == 8'(FRAME_UNITS - 1)) begin
                    cnt_unit <= '0;
`ifdef NEC_TX_REPEAT_EN
                    if (tx_repeat) begin
                        state     <= LEAD_MARK;
                        seg_left  <= 4'd15;
                        rep_frame <= 1'b1;
                        ir_env    <= 1'b1;
                        carrier   <= 1'b1;
                        car_cnt   <= '0;
                    end else begin
                        state     <= IDLE;
                        rep_frame <= 1'b0;
                        tx_busy   <= 1'b0;
                        tx_done   <= 1'b1;
                    end
`else
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
`endif
                end
`ifdef NEC_TX_REPEAT_EN
                REP_SPACE: if (seg_end) begin
                    state    <= STOP_MARK;
                    seg_left <= 4'd0;
                    ir_env   <= 1'b1;
                    carrier  <= 1'b1;
                    car_cnt  <= '0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
